// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the programmable clock divider family.
// The top-level CLKDIV_BYPASS_EN build option does not change anything in this package.
package clkdiv_pkg;

  localparam int DEF_RATIO_WIDTH = 8;

  // One-hot prescale codes; anything else decodes to divide-by-1
  localparam logic [5:0] PRESC_DIV1 = 6'b100000;
  localparam logic [5:0] PRESC_DIV2 = 6'b010000;
  localparam logic [5:0] PRESC_DIV4 = 6'b001000;
  localparam logic [5:0] PRESC_DIV8 = 6'b000100;

  typedef logic [DEF_RATIO_WIDTH-1:0] ratio_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/clkdiv_prescale_decode.sv
// Combinational prescale code to divide ratio mapping, shared with the RX sampler.
// Unrecognised codes fall back to ratio 1 so the consumer never sees a zero ratio.
module clkdiv_prescale_decode
  import clkdiv_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int OUT_WIDTH      = 8
) (
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [OUT_WIDTH-1:0]      ratio
);

  always_comb begin
    ratio = OUT_WIDTH'(1);
    if (prescale == PRESCALE_WIDTH'(PRESC_DIV1)) begin
      ratio = OUT_WIDTH'(1);
    end else if (prescale == PRESCALE_WIDTH'(PRESC_DIV2)) begin
      ratio = OUT_WIDTH'(2);
    end else if (prescale == PRESCALE_WIDTH'(PRESC_DIV4)) begin
      ratio = OUT_WIDTH'(4);
    end else if (prescale == PRESCALE_WIDTH'(PRESC_DIV8)) begin
      ratio = OUT_WIDTH'(8);
    end
  end

endmodule

// File: rtl/clkdiv_ratio_gen.sv
// Programmable clock divider: registered divided clock, end-of-period tick, glitch-free ratio changes.
// Define CLKDIV_BYPASS_EN to route CLK straight to DIV_CLK while the active ratio is 1.
module clkdiv_ratio_gen
  import clkdiv_pkg::*;
#(
  parameter int RATIO_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLK_EN,
  input  logic                      SEL_MODE,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic [RATIO_WIDTH-1:0]    DIV_RATIO,
  output logic                      DIV_CLK,
  output logic                      DIV_TICK,
  output logic [RATIO_WIDTH-1:0]    RATIO_ACTIVE,
  output logic                      UPDATE_ACK
);

  state_t                 state;
  state_t                 state_nxt;
  logic [RATIO_WIDTH-1:0] decoded;
  logic [RATIO_WIDTH-1:0] ratio_req;
  logic [RATIO_WIDTH-1:0] ratio_q;
  logic [RATIO_WIDTH-1:0] ratio_nxt;
  logic [RATIO_WIDTH-1:0] cnt;
  logic [RATIO_WIDTH-1:0] cnt_nxt;
  logic [RATIO_WIDTH-1:0] last_cnt;
  logic                   boundary;
  logic                   load_ratio;
  logic                   clk_q;
  logic                   clk_nxt;
  logic                   tick_q;
  logic                   tick_nxt;
  logic                   ack_q;
  logic                   ack_nxt;

  clkdiv_prescale_decode #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH),
    .OUT_WIDTH     (RATIO_WIDTH)
  ) u_decode (
    .prescale(PRESCALE),
    .ratio   (decoded)
  );

  // A direct ratio of 0 is meaningless, so it is treated as divide-by-1
  assign ratio_req = SEL_MODE ? ((DIV_RATIO == '0) ? RATIO_WIDTH'(1) : DIV_RATIO) : decoded;
  assign last_cnt  = ratio_q - RATIO_WIDTH'(1);
  assign boundary  = (state == RUN) && (cnt == last_cnt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CLK_EN)  state_nxt = RUN;
      RUN:     if (!CLK_EN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next-cycle outputs are computed from next-cycle count and ratio so every output is a flop
  always_comb begin
    load_ratio = (state == IDLE) || boundary;
    ratio_nxt  = load_ratio ? ratio_req : ratio_q;
    ack_nxt    = load_ratio && (ratio_req != ratio_q);
    cnt_nxt    = '0;
    if ((state == RUN) && (state_nxt == RUN) && !boundary) begin
      cnt_nxt = cnt + RATIO_WIDTH'(1);
    end
    tick_nxt = (state_nxt == RUN) && (cnt_nxt == (ratio_nxt - RATIO_WIDTH'(1)));
    clk_nxt  = (state_nxt == RUN) && (cnt_nxt < (ratio_nxt >> 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      ratio_q <= RATIO_WIDTH'(1);
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      ratio_q <= ratio_nxt;
      clk_q   <= clk_nxt;
      tick_q  <= tick_nxt;
      ack_q   <= ack_nxt;
    end
  end

`ifdef CLKDIV_BYPASS_EN
  logic bypass_q;

  // The mux select only moves when the ratio may move, so DIV_CLK cannot glitch mid-period
  always_ff @(posedge CLK) begin
    if (RST) begin
      bypass_q <= 1'b0;
    end else if (load_ratio) begin
      bypass_q <= (state_nxt == RUN) && (ratio_nxt == RATIO_WIDTH'(1));
    end
  end

  assign DIV_CLK = bypass_q ? CLK : clk_q;
`else
  assign DIV_CLK = clk_q;
`endif

  assign DIV_TICK     = tick_q;
  assign RATIO_ACTIVE = ratio_q;
  assign UPDATE_ACK   = ack_q;

endmodule
